// File: rtl/wb_mem_responder_pkg.sv
// Types and constants shared by the Wishbone memory responder and its storage.
`include "config.v"

package wb_mem_responder_pkg;

   localparam int ADDR_W  = `WB_ADDR_W;
   localparam int DATA_W  = `RW;
   localparam int BURST_4 = `WB_BURST_4;
   localparam int BURST_8 = `WB_BURST_8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BEAT
   } state_t;

   // The 8-beat flag takes priority when a master raises both flags.
   function automatic logic [3:0] beat_count(input logic b4, input logic b8);
      if (b8) begin
         return 4'(BURST_8);
      end else if (b4) begin
         return 4'(BURST_4);
      end else begin
         return 4'd1;
      end
   endfunction

endpackage

// File: rtl/config.v
// Shared Wishbone configuration: bus address/data widths and burst lengths.
`ifndef WB_CONFIG_V
`define WB_CONFIG_V
`define WB_ADDR_W  16
`define RW         16
`define WB_BURST_4 4
`define WB_BURST_8 8
`endif

// File: rtl/wb_resp_mem.sv
// Single-port 2^AW x 16 word store with byte-enable write and combinational read.
module wb_resp_mem #(
   parameter int AW = 8
) (
   input  logic          i_clk,
   input  logic          we,
   input  logic [1:0]    sel,
   input  logic [AW-1:0] adr,
   input  logic [15:0]   wdat,
   output logic [15:0]   rdat
);

   logic [15:0] mem [0:(1<<AW)-1];

   always_ff @(posedge i_clk) begin
      if (we) begin
         if (sel[0]) mem[adr][7:0]  <= wdat[7:0];
         if (sel[1]) mem[adr][15:8] <= wdat[15:8];
      end
   end

   assign rdat = mem[adr];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone slave answering single and 4/8-beat bursts from a local word memory.
// Define WB_RESP_ERR_EN to answer out-of-range beats with err instead of aliasing.
//
// state   | meaning
// IDLE    | waiting for cyc&stb; request fields are latched on acceptance
// WAIT    | fixed wait-state countdown before the first beat
// BEAT    | one ack/err per cycle for the latched beat count
`include "config.v"

module wb_mem_responder
   import wb_mem_responder_pkg::*;
#(
   parameter int MEM_AW      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic                  i_wb_we,
   input  logic [`WB_ADDR_W-1:0] i_wb_adr,
   input  logic [`RW-1:0]        i_wb_dat,
   input  logic [1:0]            i_wb_sel,
   input  logic                  i_wb_4_burst,
   input  logic                  i_wb_8_burst,
   output logic [`RW-1:0]        o_wb_dat,
   output logic                  o_wb_ack,
   output logic                  o_wb_err
);

   localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base_adr;
   logic                we_q;
   logic [1:0]          sel_q;
   logic [3:0]          n_beats;
   logic [3:0]          beat_idx;
   logic [2:0]          wait_cnt;

   logic                accept;
   logic                beat_last;
   logic                beat_bad;
   logic [ADDR_W-1:0]   beat_adr;
   logic                mem_we;
   logic [15:0]         mem_rdat;

   assign accept    = (state == ST_IDLE) && i_wb_cyc && i_wb_stb;
   assign beat_adr  = base_adr + ADDR_W'(beat_idx);
   assign beat_last = (beat_idx + 4'd1) == n_beats;

`ifdef WB_RESP_ERR_EN
   assign beat_bad = (beat_adr >> MEM_AW) != '0;
`else
   logic unused_adr_hi;
   assign unused_adr_hi = ^(beat_adr >> MEM_AW);
   assign beat_bad      = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         base_adr <= '0;
         we_q     <= 1'b0;
         sel_q    <= 2'b00;
         n_beats  <= 4'd0;
         beat_idx <= 4'd0;
         wait_cnt <= 3'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            base_adr <= i_wb_adr;
            we_q     <= i_wb_we;
            sel_q    <= i_wb_sel;
            n_beats  <= beat_count(i_wb_4_burst, i_wb_8_burst);
            beat_idx <= 4'd0;
            wait_cnt <= WAIT_LOAD;
         end
         if (state == ST_WAIT && i_wb_cyc && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if (state == ST_BEAT && i_wb_cyc) begin
            beat_idx <= beat_idx + 4'd1;
         end
      end
   end

   // Responses are gated by cyc so an aborting master never sees a stray ack.
   always_comb begin
      state_nxt = state;
      o_wb_ack  = 1'b0;
      o_wb_err  = 1'b0;
      o_wb_dat  = '0;
      mem_we    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_BEAT;
            end
         end
         ST_WAIT: begin
            if (!i_wb_cyc) begin
               state_nxt = ST_IDLE;
            end else if (wait_cnt == 3'd0) begin
               state_nxt = ST_BEAT;
            end
         end
         ST_BEAT: begin
            if (!i_wb_cyc) begin
               state_nxt = ST_IDLE;
            end else begin
               if (beat_bad) begin
                  o_wb_err = 1'b1;
               end else begin
                  o_wb_ack = 1'b1;
                  if (we_q) begin
                     mem_we = 1'b1;
                  end else begin
                     o_wb_dat = mem_rdat;
                  end
               end
               if (beat_last) begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   wb_resp_mem #(
      .AW (MEM_AW)
   ) u_mem (
      .i_clk (i_clk),
      .we    (mem_we),
      .sel   (sel_q),
      .adr   (beat_adr[MEM_AW-1:0]),
      .wdat  (i_wb_dat),
      .rdat  (mem_rdat)
   );

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: transaction-level memory model plus literal pins.
`timescale 1ns/1ps

module tb_wb_mem_responder;

   localparam int WS = 1;
`ifdef WB_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_wb_cyc, i_wb_stb, i_wb_we;
   logic [15:0] i_wb_adr, i_wb_dat;
   logic [1:0]  i_wb_sel;
   logic        i_wb_4_burst, i_wb_8_burst;
   logic [15:0] o_wb_dat;
   logic        o_wb_ack, o_wb_err;

   always #5 i_clk = ~i_clk;

   wb_mem_responder #(
      .MEM_AW      (8),
      .WAIT_STATES (WS)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_wb_cyc     (i_wb_cyc),
      .i_wb_stb     (i_wb_stb),
      .i_wb_we      (i_wb_we),
      .i_wb_adr     (i_wb_adr),
      .i_wb_dat     (i_wb_dat),
      .i_wb_sel     (i_wb_sel),
      .i_wb_4_burst (i_wb_4_burst),
      .i_wb_8_burst (i_wb_8_burst),
      .o_wb_dat     (o_wb_dat),
      .o_wb_ack     (o_wb_ack),
      .o_wb_err     (o_wb_err)
   );

   logic [15:0] mem_m [0:255];
   logic        exp_ack, exp_err;
   logic [15:0] exp_dat;
   bit          chk_en;
   int          checks, failures, cyc_no;
   logic        cap_ack [0:15];
   logic        cap_err [0:15];
   logic [15:0] cap_dat [0:15];

   always @(negedge i_clk) begin
      cyc_no++;
      if (chk_en) begin
         checks++;
         if (o_wb_ack !== exp_ack || o_wb_err !== exp_err || o_wb_dat !== exp_dat) begin
            failures++;
            $display("FAIL model_cmp cyc=%0d ack=%b exp=%b err=%b exp=%b dat=%h exp=%h",
                     cyc_no, o_wb_ack, exp_ack, o_wb_err, exp_err, o_wb_dat, exp_dat);
         end
      end
   end

   task automatic lit(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic set_exp(input logic a, input logic e, input logic [15:0] d);
      exp_ack = a;
      exp_err = e;
      exp_dat = d;
   endtask

   task automatic step(input int idx);
      @(negedge i_clk);
      cap_ack[idx] = o_wb_ack;
      cap_err[idx] = o_wb_err;
      cap_dat[idx] = o_wb_dat;
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int idx);
      i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
      i_wb_4_burst = 0; i_wb_8_burst = 0; i_rst = 0;
      set_exp(0, 0, 16'h0);
      step(idx);
   endtask

   function automatic int first_resp();
      for (int i = 0; i < 16; i++) begin
         if (cap_ack[i] === 1'b1 || cap_err[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   // One master transaction; expectations come from the bus rules, not the DUT.
   task automatic access(input bit we, input logic [15:0] adr, input logic [1:0] sel,
                         input bit b4, input bit b8, input logic [15:0] d0,
                         input logic [15:0] dstep, input int drop_at, input int rst_at,
                         input bit stb_gap, input bit no_gap);
      int          n;
      int          idx;
      logic [15:0] a;
      logic [15:0] wd;
      logic [7:0]  hi;
      bit          bad;
      n = b8 ? 8 : (b4 ? 4 : 1);
      for (int i = 0; i < 16; i++) begin
         cap_ack[i] = 0; cap_err[i] = 0; cap_dat[i] = 0;
      end
      i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_adr = adr; i_wb_sel = sel;
      i_wb_4_burst = b4; i_wb_8_burst = b8; i_wb_dat = d0;
      set_exp(0, 0, 16'h0);
      step(0);
      idx = 1;
      for (int w = 0; w < WS; w++) begin
         i_wb_stb = !stb_gap; i_wb_adr = ~adr; i_wb_sel = ~sel; i_wb_we = !we;
         i_wb_4_burst = 0; i_wb_8_burst = 0;
         set_exp(0, 0, 16'h0);
         step(idx);
         idx++;
      end
      for (int k = 0; k < n; k++) begin
         if (k == drop_at) begin
            i_wb_cyc = 0; i_wb_stb = 0;
            set_exp(0, 0, 16'h0);
            step(idx);
            return;
         end
         i_wb_cyc = 1;
         i_wb_stb = stb_gap ? ((k % 2) == 1) : 1'b1;
         wd = d0 + dstep * 16'(k);
         i_wb_dat = wd;
         i_rst = (k == rst_at);
         a  = adr + 16'(k);
         hi = a[15:8];
         bad = ERR_EN && (hi != 8'h0);
         set_exp(!bad, bad, (!we && !bad) ? mem_m[a[7:0]] : 16'h0);
         step(idx);
         idx++;
         if (we && !bad) begin
            if (sel[0]) mem_m[a[7:0]][7:0]  = wd[7:0];
            if (sel[1]) mem_m[a[7:0]][15:8] = wd[15:8];
         end
         if (k == rst_at) begin
            idle(idx);
            return;
         end
      end
      if (!no_gap) idle(idx);
   endtask

   initial begin
      checks = 0; failures = 0; cyc_no = 0; chk_en = 0;
      i_rst = 1; i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_adr = 0;
      i_wb_dat = 0; i_wb_sel = 0; i_wb_4_burst = 0; i_wb_8_burst = 0;
      set_exp(0, 0, 16'h0);
      @(posedge i_clk); #1;
      chk_en = 1;
      repeat (2) begin @(posedge i_clk); #1; end
      lit("reset_ack", o_wb_ack, 0);
      lit("reset_err", o_wb_err, 0);
      lit("reset_dat", o_wb_dat, 0);
      i_rst = 0;
      idle(0);

      // Single write then read-back, fixed two-cycle latency.
      access(1, 16'h0010, 2'b11, 0, 0, 16'hBEEF, 0, -1, -1, 0, 0);
      lit("wr_latency", first_resp(), 2);
      access(0, 16'h0010, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 0);
      lit("rd_latency", first_resp(), 2);
      lit("rd_beef", cap_dat[2], 16'hBEEF);

      // Low byte only.
      access(1, 16'h0010, 2'b01, 0, 0, 16'h1234, 0, -1, -1, 0, 0);
      access(0, 16'h0010, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 0);
      lit("byte_en", cap_dat[2], 16'hBE34);

      // 8-beat write of 0..7 then 8-beat read.
      access(1, 16'h0020, 2'b11, 0, 1, 16'h0, 16'h1, -1, -1, 0, 0);
      access(0, 16'h0020, 2'b11, 0, 1, 16'h0, 0, -1, -1, 0, 0);
      for (int k = 0; k < 8; k++) begin
         lit($sformatf("b8_ack%0d", k), cap_ack[2+k], 1);
         lit($sformatf("b8_dat%0d", k), cap_dat[2+k], k);
      end
      lit("b8_ack_after", cap_ack[10], 0);

      // 4-beat write aborted at beat 2.
      access(1, 16'h0040, 2'b11, 1, 0, 16'hAAAA, 0, -1, -1, 0, 0);
      access(1, 16'h0040, 2'b11, 1, 0, 16'h0001, 16'h1, 2, -1, 0, 0);
      lit("abort_no_ack", cap_ack[4], 0);
      idle(0);
      access(0, 16'h0040, 2'b11, 1, 0, 16'h0, 0, -1, -1, 0, 0);
      lit("abort_w0", cap_dat[2], 16'h0001);
      lit("abort_w1", cap_dat[3], 16'h0002);
      lit("abort_w2", cap_dat[4], 16'hAAAA);
      lit("abort_w3", cap_dat[5], 16'hAAAA);

      // Out-of-range word 0x100.
      access(1, 16'h0000, 2'b11, 0, 0, 16'h5A5A, 0, -1, -1, 0, 0);
      access(0, 16'h0100, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 0);
`ifdef WB_RESP_ERR_EN
      lit("oor_err", cap_err[2], 1);
      lit("oor_ack", cap_ack[2], 0);
      lit("oor_dat", cap_dat[2], 0);
`else
      lit("alias_ack", cap_ack[2], 1);
      lit("alias_dat", cap_dat[2], 16'h5A5A);
`endif

      // Reset during beat 3 of an 8-beat read, then a fresh single read.
      access(0, 16'h0020, 2'b11, 0, 1, 16'h0, 0, -1, 3, 0, 0);
      lit("rst_beat3_dat", cap_dat[5], 3);
      lit("rst_next_ack", cap_ack[6], 0);
      access(0, 16'h0023, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 0);
      lit("post_rst_lat", first_resp(), 2);
      lit("post_rst_dat", cap_dat[2], 3);

      // Earliest re-acceptance: the cycle right after the last ack.
      access(0, 16'h0010, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 1);
      lit("b2b_first", cap_dat[2], 16'hBE34);
      access(0, 16'h0021, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 0);
      lit("b2b_lat", first_resp(), 2);
      lit("b2b_dat", cap_dat[2], 1);

      // Both burst flags: 8 beats.
      access(0, 16'h0020, 2'b11, 1, 1, 16'h0, 0, -1, -1, 0, 0);
      lit("both_last_ack", cap_ack[9], 1);
      lit("both_last_dat", cap_dat[9], 7);

      // stb toggling mid-burst does not stall.
      access(0, 16'h0020, 2'b11, 1, 0, 16'h0, 0, -1, -1, 1, 0);
      lit("stb_gap_last", cap_dat[5], 3);

      // Burst straddling the top of memory.
      access(1, 16'h00FE, 2'b11, 1, 0, 16'hC000, 16'h1, -1, -1, 0, 0);
      access(0, 16'h00FF, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 0);
      lit("wrap_ff", cap_dat[2], 16'hC001);
      access(0, 16'h0000, 2'b11, 0, 0, 16'h0, 0, -1, -1, 0, 0);
`ifdef WB_RESP_ERR_EN
      lit("wrap_w0_kept", cap_dat[2], 16'h5A5A);
`else
      lit("wrap_w0_alias", cap_dat[2], 16'hC002);
`endif

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
